// File: rtl/ahb_m2s_pipe_mux.sv
// AHB master-to-slave multiplexer: address phase follows the current grant, write data follows
// the owner of the previous accepted address phase. Optional handover checker: AHB_M2S_HANDOVER_CHK_EN.
module ahb_m2s_pipe_mux #(
    parameter int  NUM_MASTERS = 4,
    parameter int  ADDR_WIDTH  = 32,
    parameter int  DATA_WIDTH  = 32,
    localparam int MW          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    localparam int SW          = DATA_WIDTH / 8
) (
    input  logic                                  Hclk,
    input  logic                                  Hresetn,
    input  logic                                  Hready,
    input  logic [MW-1:0]                         Hmaster,
    input  logic                                  Hmaster_valid,
    input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] Haddr_M,
    input  logic [NUM_MASTERS-1:0][1:0]            Htrans_M,
    input  logic [NUM_MASTERS-1:0]                 Hwrite_M,
    input  logic [NUM_MASTERS-1:0][2:0]            Hsize_M,
    input  logic [NUM_MASTERS-1:0][2:0]            Hburst_M,
    input  logic [NUM_MASTERS-1:0][SW-1:0]         Hstrob_M,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] Hwdata_M,
    output logic [ADDR_WIDTH-1:0]                 Haddr,
    output logic [1:0]                            Htrans,
    output logic                                  Hwrite,
    output logic [2:0]                            Hsize,
    output logic [2:0]                            Hburst,
    output logic [SW-1:0]                         Hstrob,
    output logic [DATA_WIDTH-1:0]                 Hwdata,
    output logic [MW-1:0]                         Hmaster_d,
    output logic                                  Hdata_active,
    output logic                                  Hdata_write
`ifdef AHB_M2S_HANDOVER_CHK_EN
    ,
    output logic                                  Hhandover_err
`endif
);

    localparam logic [1:0] TRANS_IDLE = 2'b00;
    localparam logic [1:0] TRANS_SEQ  = 2'b11;
    localparam logic [1:0] TRANS_NSEQ = 2'b10;

    logic                   w_sel_ok;
    logic [NUM_MASTERS-1:0] w_addr_hit;
    logic [NUM_MASTERS-1:0] w_data_hit;
    logic                   w_accept;
    logic [ADDR_WIDTH-1:0]  w_haddr;
    logic [1:0]             w_htrans;
    logic                   w_hwrite;
    logic [2:0]             w_hsize;
    logic [2:0]             w_hburst;
    logic [SW-1:0]          w_hstrob;
    logic [DATA_WIDTH-1:0]  w_hwdata;

    logic [MW-1:0]          r_master_d;
    logic                   r_data_active;
    logic                   r_data_write;

    // Widened compare so a non-power-of-two master count rejects the unused indices.
    assign w_sel_ok = Hmaster_valid && ({1'b0, Hmaster} < (MW+1)'(NUM_MASTERS));

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_hit
            assign w_addr_hit[gi] = w_sel_ok && (Hmaster == MW'(gi));
            assign w_data_hit[gi] = r_data_write && (r_master_d == MW'(gi));
        end
    endgenerate

    // One-hot AND-OR muxes: no hit yields IDLE / all-zero outputs.
    always_comb begin
        w_haddr  = '0;
        w_htrans = TRANS_IDLE;
        w_hwrite = 1'b0;
        w_hsize  = '0;
        w_hburst = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_addr_hit[i]) begin
                w_haddr  = w_haddr  | Haddr_M[i];
                w_htrans = w_htrans | Htrans_M[i];
                w_hwrite = w_hwrite | Hwrite_M[i];
                w_hsize  = w_hsize  | Hsize_M[i];
                w_hburst = w_hburst | Hburst_M[i];
            end
        end
    end

    always_comb begin
        w_hwdata = '0;
        w_hstrob = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_data_hit[i]) begin
                w_hwdata = w_hwdata | Hwdata_M[i];
                w_hstrob = w_hstrob | Hstrob_M[i];
            end
        end
    end

    assign w_accept = Hready && w_sel_ok && w_htrans[1];

    // Data-phase owner advances only when the current data phase completes.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_master_d    <= '0;
            r_data_active <= 1'b0;
            r_data_write  <= 1'b0;
        end else if (Hready) begin
            r_master_d    <= Hmaster;
            r_data_active <= w_accept;
            r_data_write  <= w_accept && w_hwrite;
        end
    end

    assign Haddr        = w_haddr;
    assign Htrans       = w_htrans;
    assign Hwrite       = w_hwrite;
    assign Hsize        = w_hsize;
    assign Hburst       = w_hburst;
    assign Hwdata       = w_hwdata;
    assign Hstrob       = w_hstrob;
    assign Hmaster_d    = r_master_d;
    assign Hdata_active = r_data_active;
    assign Hdata_write  = r_data_write;

`ifdef AHB_M2S_HANDOVER_CHK_EN
    logic [MW-1:0] r_last_master;
    logic          r_burst_open;
    logic          r_handover_err;
    logic          w_seq_acc;
    logic          w_nseq_acc;
    logic          w_idle_acc;

    assign w_seq_acc  = w_accept && (w_htrans == TRANS_SEQ);
    assign w_nseq_acc = w_accept && (w_htrans == TRANS_NSEQ);
    assign w_idle_acc = Hready && w_sel_ok && (w_htrans == TRANS_IDLE);

    // r_data_active doubles as "previous accepted phase was NONSEQ/SEQ".
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_last_master  <= '0;
            r_burst_open   <= 1'b0;
            r_handover_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_last_master <= Hmaster;
            end
            if (w_nseq_acc && (w_hburst != 3'b000)) begin
                r_burst_open <= 1'b1;
            end else if (w_idle_acc || (Hready && w_sel_ok && (Hmaster != r_last_master))) begin
                r_burst_open <= 1'b0;
            end
            if (w_seq_acc && ((Hmaster != r_last_master) || !r_data_active)) begin
                r_handover_err <= 1'b1;
            end
        end
    end

    assign Hhandover_err = r_handover_err;
`endif

endmodule
